// File: rtl/vga_timing.sv
// Raster timing generator: free-running h/v counters with registered flags and
// strobes, plus hsync/vsync/de delayed PIPE pixel advances to match the pixel stage.
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int PIPE     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    output logic [10:0] hcnt,
    output logic [9:0]  vcnt,
    output logic        active,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        de
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_INV = (HS_POL == 0);
    localparam logic VS_INV = (VS_POL == 0);

    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        vblank_q, vblank_d;
    logic        hwrap;

    // Each stage is {active, vs_raw, hs_raw}; stage 0 is aligned with the counters.
    logic [PIPE:0][2:0] pipe_q;
    logic [2:0]         raw_d;

    always_comb begin
        hwrap  = (hcnt_q == H_LAST);
        hcnt_d = hwrap ? 11'd0 : hcnt_q + 11'd1;
        vcnt_d = vcnt_q;
        if (hwrap) begin
            vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
        end
    end

    // Flags are computed from the next counter values so they describe the
    // counters they are registered alongside.
    always_comb begin
        raw_d[0]      = (hcnt_d >= HS_START) && (hcnt_d < HS_END);
        raw_d[1]      = (vcnt_d >= VS_START) && (vcnt_d < VS_END);
        raw_d[2]      = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
        line_start_d  = (hcnt_d == 11'd0);
        frame_start_d = (hcnt_d == 11'd0) && (vcnt_d == 10'd0);
        vblank_d      = (vcnt_d >= V_ACT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcnt_q        <= H_LAST;
            vcnt_q        <= V_LAST;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b1;
            pipe_q        <= '0;
        end else if (ena) begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            vblank_q      <= vblank_d;
            pipe_q[0]     <= raw_d;
            for (int i = 1; i <= PIPE; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign active      = pipe_q[0][2];
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign vblank      = vblank_q;
    assign vga_hs      = pipe_q[PIPE][0] ^ HS_INV;
    assign vga_vs      = pipe_q[PIPE][1] ^ VS_INV;
    assign de          = pipe_q[PIPE][2];

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: default 800x600 instance plus a small raster instance
// (inverted hsync, PIPE=3) so whole frames fit in a short run.
module tb_vga_timing;

    logic clk;
    logic rst_n;
    logic ena;

    logic [10:0] hcnt_a, hcnt_b;
    logic [9:0]  vcnt_a, vcnt_b;
    logic active_a, line_start_a, frame_start_a, vblank_a, vga_hs_a, vga_vs_a, de_a;
    logic active_b, line_start_b, frame_start_b, vblank_b, vga_hs_b, vga_vs_b, de_b;

    vga_timing dut_a (
        .clk(clk), .reset(rst_n), .ena(ena),
        .hcnt(hcnt_a), .vcnt(vcnt_a), .active(active_a), .line_start(line_start_a),
        .frame_start(frame_start_a), .vblank(vblank_a), .vga_hs(vga_hs_a),
        .vga_vs(vga_vs_a), .de(de_a)
    );

    vga_timing #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(6),
        .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .HS_POL(0), .VS_POL(1), .PIPE(3)
    ) dut_b (
        .clk(clk), .reset(rst_n), .ena(ena),
        .hcnt(hcnt_b), .vcnt(vcnt_b), .active(active_b), .line_start(line_start_b),
        .frame_start(frame_start_b), .vblank(vblank_b), .vga_hs(vga_hs_b),
        .vga_vs(vga_vs_b), .de(de_b)
    );

    logic [27:0] obs_a, obs_b;
    assign obs_a = {hcnt_a, vcnt_a, active_a, line_start_a, frame_start_a, vblank_a,
                    vga_hs_a, vga_vs_a, de_a};
    assign obs_b = {hcnt_b, vcnt_b, active_b, line_start_b, frame_start_b, vblank_b,
                    vga_hs_b, vga_vs_b, de_b};

    int     checks = 0;
    int     errors = 0;
    longint n      = -1;   // pixel advances since reset release; -1 = reset state
    logic [27:0] exp_a, exp_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: position of advance n is plain division of n by the raster size;
    // delayed outputs are the same rules applied at n-pipe.
    function automatic logic [27:0] model(input longint k, input int ha, hf, hs, hb,
                                          input int va, vf, vs, vb, hp, vp, pp);
        int ht, vt, h, v, hd, vd;
        logic act, ls, fs, vbl, hsr, vsr, der;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (k < 0) begin
            h = ht - 1; v = vt - 1;
        end else begin
            h = int'(k % ht); v = int'((k / ht) % vt);
        end
        act = (k >= 0) && (h < ha) && (v < va);
        ls  = (k >= 0) && (h == 0);
        fs  = ls && (v == 0);
        vbl = (v >= va);
        if (k - pp < 0) begin
            hsr = 1'b0; vsr = 1'b0; der = 1'b0;
        end else begin
            hd  = int'((k - pp) % ht);
            vd  = int'(((k - pp) / ht) % vt);
            hsr = (hd >= ha + hf) && (hd < ha + hf + hs);
            vsr = (vd >= va + vf) && (vd < va + vf + vs);
            der = (hd < ha) && (vd < va);
        end
        return {11'(h), 10'(v), act, ls, fs, vbl,
                (hp != 0) ? hsr : ~hsr, (vp != 0) ? vsr : ~vsr, der};
    endfunction

    function automatic logic [27:0] model_a(input longint k);
        return model(k, 800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 2);
    endfunction

    function automatic logic [27:0] model_b(input longint k);
        return model(k, 16, 4, 8, 6, 10, 1, 2, 3, 0, 1, 3);
    endfunction

    task automatic step(input logic e);
        ena = e;
        @(posedge clk);
        if (e && rst_n) n++;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        ena   = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n = -1;
        checks++;
        if (obs_a !== 28'({11'd1055, 10'd627, 7'b0001000})) begin
            errors++;
            $display("FAIL reset_const got=%h exp=%h", obs_a, {11'd1055, 10'd627, 7'b0001000});
        end
        repeat (3) step(1'b1);
        exp_a = model_a(n); exp_b = model_b(n);
        checks++;
        if (obs_a !== exp_a) begin
            errors++; $display("FAIL reset_a got=%h exp=%h", obs_a, exp_a);
        end
        checks++;
        if (obs_b !== exp_b) begin
            errors++; $display("FAIL reset_b got=%h exp=%h", obs_b, exp_b);
        end
    endtask

    task automatic test_first_edges;
        rst_n = 1'b1;
        step(1'b1);
        checks++;
        if ({hcnt_a, vcnt_a, frame_start_a, line_start_a, active_a, vblank_a} !==
            {11'd0, 10'd0, 4'b1110}) begin
            errors++;
            $display("FAIL first_edge got h=%0d v=%0d fs=%b ls=%b act=%b vbl=%b",
                     hcnt_a, vcnt_a, frame_start_a, line_start_a, active_a, vblank_a);
        end
        step(1'b1);
        exp_a = model_a(n);
        checks++;
        if (obs_a !== exp_a || hcnt_a !== 11'd1 || frame_start_a !== 1'b0) begin
            errors++; $display("FAIL second_edge got=%h exp=%h", obs_a, exp_a);
        end
    endtask

    task automatic test_line;
        int   hs_first = -1, hs_cnt = 0, de_fall = -1;
        logic de_prev = 1'b0;
        for (int c = 0; c < 2200; c++) begin
            step(1'b1);
            exp_a = model_a(n); exp_b = model_b(n);
            checks++;
            if (obs_a !== exp_a) begin
                errors++; $display("FAIL line_a n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++; $display("FAIL line_b n=%0d got=%h exp=%h", n, obs_b, exp_b);
            end
            if (vcnt_a == 10'd0) begin
                if (vga_hs_a === 1'b1) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(hcnt_a);
                end
                if (de_prev && de_a === 1'b0 && de_fall < 0) de_fall = int'(hcnt_a);
            end
            de_prev = de_a;
        end
        checks++;
        if (hs_first != 842 || hs_cnt != 128) begin
            errors++;
            $display("FAIL hsync_window got first=%0d count=%0d exp first=842 count=128",
                     hs_first, hs_cnt);
        end
        checks++;
        if (de_fall != 802) begin
            errors++; $display("FAIL de_fall got=%0d exp=802", de_fall);
        end
    endtask

    task automatic test_ena_sparse;
        for (int c = 0; c < 4000; c++) begin
            step((c < 2000) ? (c % 4 == 0) : 1'($urandom_range(0, 1)));
            exp_a = model_a(n); exp_b = model_b(n);
            checks++;
            if (obs_a !== exp_a) begin
                errors++; $display("FAIL ena_a n=%0d got=%h exp=%h", n, obs_a, exp_a);
            end
            checks++;
            if (obs_b !== exp_b) begin
                errors++; $display("FAIL ena_b n=%0d got=%h exp=%h", n, obs_b, exp_b);
            end
        end
    endtask

    task automatic test_frame;
        int pulses = 0, last = 0, period = -1, vs_cnt = 0, vs_frame = -1;
        for (int c = 0; c < 1300; c++) begin
            step(1'b1);
            exp_b = model_b(n);
            checks++;
            if (obs_b !== exp_b) begin
                errors++; $display("FAIL frame_b n=%0d got=%h exp=%h", n, obs_b, exp_b);
            end
            if (frame_start_b === 1'b1) begin
                if (pulses == 1) begin
                    period   = c - last;
                    vs_frame = vs_cnt;
                end
                pulses++;
                last   = c;
                vs_cnt = 0;
            end
            if (vga_vs_b === 1'b1) vs_cnt++;
        end
        checks++;
        if (pulses < 2 || period != 544 || vs_frame != 68) begin
            errors++;
            $display("FAIL frame_period got pulses=%0d period=%0d vs=%0d exp period=544 vs=68",
                     pulses, period, vs_frame);
        end
    endtask

    task automatic test_reset_mid;
        repeat ($urandom_range(50, 500)) step(1'b1);
        #2 rst_n = 1'b0;
        #1;
        n = -1;
        exp_a = model_a(n); exp_b = model_b(n);
        checks++;
        if (obs_a !== exp_a || obs_b !== exp_b) begin
            errors++;
            $display("FAIL mid_reset got a=%h b=%h exp a=%h b=%h", obs_a, obs_b, exp_a, exp_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0);
        exp_a = model_a(n);
        checks++;
        if (obs_a !== exp_a) begin
            errors++; $display("FAIL hold_after_release got=%h exp=%h", obs_a, exp_a);
        end
        for (int c = 0; c < 40; c++) begin
            step(1'b1);
            exp_a = model_a(n); exp_b = model_b(n);
            checks++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                errors++;
                $display("FAIL restart n=%0d got a=%h b=%h exp a=%h b=%h",
                         n, obs_a, obs_b, exp_a, exp_b);
            end
            if (c == 0) begin
                checks++;
                if (frame_start_a !== 1'b1 || hcnt_a !== 11'd0 || vcnt_a !== 10'd0) begin
                    errors++;
                    $display("FAIL restart_origin got h=%0d v=%0d fs=%b", hcnt_a, vcnt_a,
                             frame_start_a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_edges();
        test_line();
        test_ena_sparse();
        test_frame();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
